if_seg: RTL and testbench
=========================

Name: if_seg

Overview:
- Instruction-fetch pipeline segment: owns the PC and issues word fetches on a req/ready instruction-memory port.
- Produces the NPC/IR pair consumed by the decode segment's NPCi/IR inputs.
- Honours a decode-side stall and an EX-side redirect (branch/jump flush).
- Sits between instruction memory and the decode segment.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word driven on IRo during bubbles/flush

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on the rising edge)
stall  input  1  decode hazard stall; hold IRo/NPCo/valid_o
redirect  input  1  flush and load redirect_pc (branch taken / jump)
redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced to 0
imem_req  output  1  fetch request
imem_addr  output  32  fetch word address; stable while imem_req=1 and no ready seen
imem_ready  input  1  response strobe; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
NPCo  output  32  address of fetched instruction + 4
IRo  output  32  fetched instruction
valid_o  output  1  IRo/NPCo hold a real instruction (0 = bubble)

Behaviour:
- Reset (rst=0 at edge): PC=RESET_PC, addr_q=RESET_PC, IRo=NOP_WORD, NPCo=0, valid_o=0, buf=0, drop=0, state=IDLE. imem_req=0 while in IDLE.
- States: IDLE, FETCH, FULL.
  - IDLE: next edge -> FETCH with addr_q=PC.
  - FETCH: imem_req=1, imem_addr=addr_q.
  - FULL: imem_req=0; the fetched word waits in buf.
- Memory protocol: a transaction completes on an edge where imem_req=1 and imem_ready=1. addr_q does not change while a transaction is pending. Back-to-back completions are allowed (one per cycle).
- FETCH, ready=1, drop=0, stall=0:
  - IRo=imem_rdata, NPCo=addr_q+4, valid_o=1.
  - PC=addr_q+4, addr_q=addr_q+4.
  - Result: 1-cycle fetch latency when ready is immediate.
- FETCH, ready=1, drop=0, stall=1: buf=imem_rdata, PC=addr_q+4, -> FULL. IRo/NPCo/valid_o hold.
- FETCH, ready=0:
  - stall=1: outputs hold.
  - stall=0: IRo=NOP_WORD, valid_o=0, NPCo holds.
- FETCH, ready=1, drop=1: discard imem_rdata, drop=0, addr_q=PC (the redirect target). Outputs stay bubble.
- FULL, stall=0: IRo=buf, NPCo=PC, valid_o=1, addr_q=PC, -> FETCH.
- FULL, stall=1: hold everything.
- Redirect (highest priority; overrides stall and state):
  - PC={redirect_pc[31:2],2'b00}, IRo=NOP_WORD, valid_o=0, buf cleared, -> FETCH.
  - From FETCH with a pending transaction and ready=0: drop=1 and addr_q unchanged; the old transaction completes and is discarded.
  - From FETCH with ready=1 in the same cycle: that response is discarded, drop=0, addr_q=new PC.
  - From IDLE or FULL: addr_q=new PC immediately.
  - A second redirect while drop=1: PC updates again; drop stays 1.
- Reset has priority over redirect and takes effect mid-transaction. The memory must tolerate request withdrawal.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, and NPCo=0 for that fetch.

Decomposition:
- Shared package: state encoding (IDLE/FETCH/FULL), NOP_WORD, INSN_BYTES=4 constant.
- No sub-module is needed; the PC incrementer is inline.
- Optional sub-module if_skid_buf for buf plus FULL control, if reuse by the MEM segment is wanted.

Test Plan:
- Reset release, memory always ready, no stall -> addresses 0,4,8 issued on consecutive cycles; IRo follows rdata one edge later; NPCo=4,8,12; valid_o=1 from the 2nd edge.
- Memory ready every 3rd cycle -> IRo=NOP_WORD and valid_o=0 on the non-ready cycles; imem_addr is held constant until ready.
- stall=1 for 4 cycles while a fetch of 32'h2002_0005 completes -> state FULL and imem_req=0; IRo holds the previous word; one edge after stall drops, IRo=32'h2002_0005 and fetching resumes at the next address.
- redirect to 32'h0000_0103 while a fetch at 8 is pending (ready arrives 2 cycles later) -> the response for 8 is discarded; next imem_addr=32'h0000_0100; valid_o=0 until the word from 0x100 is delivered with NPCo=0x104.
- redirect and stall both high in the same cycle, and redirect coinciding with ready -> flush wins; IRo=NOP_WORD; no stale word ever appears with valid_o=1.
- rst=0 asserted during a pending fetch with PC near 32'hFFFF_FFFC -> next cycle all outputs are at their reset values; separately, the wrap case yields NPCo=0.

Source files
------------

// File: rtl/if_seg_pkg.sv
// if_seg_pkg: shared state encoding and constants for the instruction-fetch segment
package if_seg_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0000;
    localparam logic [31:0] INSN_BYTES = 32'd4;
endpackage

// File: rtl/if_seg.sv
// if_seg: instruction-fetch segment owning the PC and producing NPCo/IRo for decode
module if_seg
    import if_seg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] NPCo,
    output logic [31:0] IRo,
    output logic        valid_o
);
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_ir;
    logic [31:0] r_npc;
    logic        r_valid;
    logic [31:0] r_buf;
    logic        r_drop;
    logic [31:0] w_addr_inc;
    logic [31:0] w_redir_pc;

    assign w_addr_inc = r_addr + INSN_BYTES;
    assign w_redir_pc = redirect_pc & ~32'h0000_0003;
    assign imem_req   = (r_state == FETCH);
    assign imem_addr  = r_addr;
    assign NPCo       = r_npc;
    assign IRo        = r_ir;
    assign valid_o    = r_valid;

    // Fetch FSM: redirect flushes first, otherwise advance on completed transactions
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_ir    <= NOP_WORD;
            r_npc   <= 32'h0;
            r_valid <= 1'b0;
            r_buf   <= 32'h0;
            r_drop  <= 1'b0;
        end else if (redirect) begin
            r_state <= FETCH;
            r_pc    <= w_redir_pc;
            r_ir    <= NOP_WORD;
            r_valid <= 1'b0;
            r_buf   <= 32'h0;
            if (r_state == FETCH && !imem_ready) begin
                r_drop <= 1'b1;
            end else begin
                r_drop <= 1'b0;
                r_addr <= w_redir_pc;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_addr  <= r_pc;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (r_drop) begin
                            r_drop <= 1'b0;
                            r_addr <= r_pc;
                        end else if (!stall) begin
                            r_ir    <= imem_rdata;
                            r_npc   <= w_addr_inc;
                            r_valid <= 1'b1;
                            r_pc    <= w_addr_inc;
                            r_addr  <= w_addr_inc;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_pc    <= w_addr_inc;
                            r_state <= FULL;
                        end
                    end else if (!stall) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        r_ir    <= r_buf;
                        r_npc   <= r_pc;
                        r_valid <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_seg.sv
// tb_if_seg: directed-vector bench for the instruction-fetch segment
module tb_if_seg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] NPCo;
    logic [31:0] IRo;
    logic        valid_o;
    int          n_checks = 0;
    int          n_fail = 0;

    if_seg dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .NPCo(NPCo), .IRo(IRo), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [31:0] rd, input logic stl,
                       input logic rdr, input logic [31:0] rpc);
        imem_ready  = rdy;
        imem_rdata  = rd;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] ir, input logic [31:0] npc, input logic vld);
        chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".ir"}, IRo, ir);
        chk({tag, ".npc"}, NPCo, npc);
        chk({tag, ".valid"}, {31'h0, valid_o}, {31'h0, vld});
    endtask

    initial begin
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        expect_out("reset", 0, 32'h0, 32'h0, 32'h0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        expect_out("idle2fetch", 1, 32'h0, 32'h0, 32'h0, 0);
        cyc(1, 32'hA000_0000, 0, 0, 0);
        expect_out("seq0", 1, 32'h4, 32'hA000_0000, 32'h4, 1);
        cyc(1, 32'hA000_0001, 0, 0, 0);
        expect_out("seq1", 1, 32'h8, 32'hA000_0001, 32'h8, 1);
        cyc(1, 32'hA000_0002, 0, 0, 0);
        expect_out("seq2", 1, 32'hC, 32'hA000_0002, 32'hC, 1);
        cyc(0, 32'hBAD0_0000, 0, 0, 0);
        expect_out("wait1", 1, 32'hC, 32'h0, 32'hC, 0);
        cyc(0, 32'hBAD0_0001, 0, 0, 0);
        expect_out("wait2", 1, 32'hC, 32'h0, 32'hC, 0);
        cyc(1, 32'hA000_0003, 0, 0, 0);
        expect_out("ready3", 1, 32'h10, 32'hA000_0003, 32'h10, 1);
        cyc(1, 32'h2002_0005, 1, 0, 0);
        expect_out("stall_full", 0, 32'h10, 32'hA000_0003, 32'h10, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'hBAD0_0002, 1, 0, 0);
            expect_out("stall_hold", 0, 32'h10, 32'hA000_0003, 32'h10, 1);
        end
        cyc(0, 32'h0, 0, 0, 0);
        expect_out("unstall", 1, 32'h14, 32'h2002_0005, 32'h14, 1);
        cyc(1, 32'hBAD0_0003, 1, 1, 32'h0000_0200);
        expect_out("redir_stall_ready", 1, 32'h200, 32'h0, 32'h14, 0);
        cyc(1, 32'hC000_0000, 1, 0, 0);
        expect_out("post_redir_stall", 0, 32'h200, 32'h0, 32'h14, 0);
        cyc(0, 32'h0, 0, 0, 0);
        expect_out("post_redir_deliver", 1, 32'h204, 32'hC000_0000, 32'h204, 1);
        cyc(0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        expect_out("redir_pending", 1, 32'h204, 32'h0, 32'h204, 0);
        cyc(1, 32'hBAD0_0004, 0, 0, 0);
        expect_out("drop_resp", 1, 32'hFFFF_FFFC, 32'h0, 32'h204, 0);
        cyc(1, 32'hD000_0000, 0, 0, 0);
        expect_out("wrap", 1, 32'h0, 32'hD000_0000, 32'h0, 1);
        cyc(1, 32'hD000_0001, 0, 0, 0);
        expect_out("after_wrap", 1, 32'h4, 32'hD000_0001, 32'h4, 1);
        cyc(1, 32'hBAD0_0005, 0, 1, 32'hFFFF_FFFF);
        expect_out("redir_ready_near_top", 1, 32'hFFFF_FFFC, 32'h0, 32'h4, 0);
        cyc(0, 32'h0, 0, 0, 0);
        expect_out("pending_top", 1, 32'hFFFF_FFFC, 32'h0, 32'h4, 0);
        rst = 1'b0;
        cyc(0, 32'h0, 0, 1, 32'h0000_0400);
        expect_out("reset_midtxn", 0, 32'h0, 32'h0, 32'h0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        expect_out("restart", 1, 32'h0, 32'h0, 32'h0, 0);
        cyc(1, 32'hE000_0000, 0, 0, 0);
        cyc(1, 32'hE000_0001, 0, 0, 0);
        expect_out("reach8", 1, 32'h8, 32'hE000_0001, 32'h8, 1);
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 0, 1, 32'h0000_0103);
        expect_out("redir_at8", 1, 32'h8, 32'h0, 32'h8, 0);
        cyc(0, 32'h0, 0, 0, 0);
        expect_out("drop_wait", 1, 32'h8, 32'h0, 32'h8, 0);
        cyc(1, 32'hBAD0_0008, 0, 0, 0);
        expect_out("drop8", 1, 32'h100, 32'h0, 32'h8, 0);
        cyc(1, 32'hF000_0100, 0, 0, 0);
        expect_out("target", 1, 32'h104, 32'hF000_0100, 32'h104, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
